// File: rtl/rgb2hsv.sv
// rtl/rgb2hsv.sv - pipelined RGB to packed HSV converter for the keyer
//
// Purpose:
//   Converts one 24-bit RGB pixel per clock into the packed HSV word
//   {hue[8:0] 0..359, sat[6:0] 0..100, val[7:0] 0..255}. Four arithmetic
//   stages (extrema/select, products, quotients, hue correction + pack)
//   followed by LATENCY-4 plain delay stages. A valid bit and a 24-bit
//   sideband word ride through shift registers of the same depth.
//
// Ports:
//   clk        pixel clock, rising edge
//   rst_n      asynchronous active-low reset, clears every pipeline register
//   in_valid   pixel_in / pass_in carry a valid pixel this cycle
//   pixel_in   {R[23:16], G[15:8], B[7:0]}
//   pass_in    opaque sideband word
//   out_valid  in_valid delayed by LATENCY
//   pixel_out  {hue[8:0], sat[6:0], val[7:0]}
//   pass_thru  pass_in delayed by LATENCY
//
// LATENCY must be 4 or more.

module rgb2hsv #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [23:0] pixel_in,
  input  logic [23:0] pass_in,
  output logic        out_valid,
  output logic [23:0] pixel_out,
  output logic [23:0] pass_thru
);

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_e;

  logic [7:0] r_ch, g_ch, b_ch;
  assign r_ch = pixel_in[23:16];
  assign g_ch = pixel_in[15:8];
  assign b_ch = pixel_in[7:0];

  // ---------------------------------------------------------------------
  // Stage 1: extrema, max-channel select, |n| and its sign
  // ---------------------------------------------------------------------
  logic [7:0] s1_mx_d, s1_mn_d, s1_d_d, s1_absn_d;
  logic       s1_neg_d;
  ch_e        s1_sel_d;

  logic [7:0] s1_mx_q, s1_d_q, s1_absn_q;
  logic       s1_neg_q;
  ch_e        s1_sel_q;

  always_comb begin
    s1_mx_d   = r_ch;
    s1_mn_d   = r_ch;
    s1_sel_d  = CH_R;
    s1_neg_d  = 1'b0;
    s1_absn_d = 8'd0;

    // Tie priority R > G > B falls out of the >= comparisons.
    if (r_ch >= g_ch && r_ch >= b_ch) begin
      s1_mx_d   = r_ch;
      s1_sel_d  = CH_R;
      s1_neg_d  = (b_ch > g_ch);
      s1_absn_d = (b_ch > g_ch) ? (b_ch - g_ch) : (g_ch - b_ch);
    end else if (g_ch >= b_ch) begin
      s1_mx_d   = g_ch;
      s1_sel_d  = CH_G;
      s1_neg_d  = (r_ch > b_ch);
      s1_absn_d = (r_ch > b_ch) ? (r_ch - b_ch) : (b_ch - r_ch);
    end else begin
      s1_mx_d   = b_ch;
      s1_sel_d  = CH_B;
      s1_neg_d  = (g_ch > r_ch);
      s1_absn_d = (g_ch > r_ch) ? (g_ch - r_ch) : (r_ch - g_ch);
    end

    if (g_ch < s1_mn_d) s1_mn_d = g_ch;
    if (b_ch < s1_mn_d) s1_mn_d = b_ch;
    s1_d_d = s1_mx_d - s1_mn_d;
  end

  // ---------------------------------------------------------------------
  // Stage 2: 60*|n| and 100*d
  // ---------------------------------------------------------------------
  logic [13:0] s2_hprod_d, s2_hprod_q;
  logic [14:0] s2_sprod_d, s2_sprod_q;
  logic [7:0]  s2_d_q, s2_mx_q;
  logic        s2_neg_q;
  ch_e         s2_sel_q;

  always_comb begin
    s2_hprod_d = 14'(s1_absn_q) * 14'd60;
    s2_sprod_d = 15'(s1_d_q) * 15'd100;
  end

  // ---------------------------------------------------------------------
  // Stage 3: exact quotients; zero divisors force a zero quotient
  // ---------------------------------------------------------------------
  logic [5:0] s3_q_d, s3_q_q;
  logic [6:0] s3_sat_d, s3_sat_q;
  logic       s3_dz_q, s3_neg_q;
  logic [7:0] s3_mx_q;
  ch_e        s3_sel_q;

  always_comb begin
    s3_q_d   = 6'd0;
    s3_sat_d = 7'd0;
    if (s2_d_q != 8'd0) begin
      s3_q_d = 6'(s2_hprod_q / 14'(s2_d_q));
    end
    if (s2_mx_q != 8'd0) begin
      s3_sat_d = 7'(s2_sprod_q / 15'(s2_mx_q));
    end
  end

  // ---------------------------------------------------------------------
  // Stage 4: base offset, sign, wrap and pack
  // ---------------------------------------------------------------------
  logic [8:0]  s4_base;
  logic [8:0]  s4_hue_d;
  logic [23:0] s4_px_d, s4_px_q;

  always_comb begin
    case (s3_sel_q)
      CH_R:    s4_base = 9'd0;
      CH_G:    s4_base = 9'd120;
      default: s4_base = 9'd240;
    endcase

    s4_hue_d = 9'd0;
    if (!s3_dz_q) begin
      if (!s3_neg_q) begin
        s4_hue_d = s4_base + 9'(s3_q_q);
      end else if (s3_sel_q == CH_R) begin
        // Only the red sector can go below zero; q = 0 stays at 0 so
        // that 360 is never emitted.
        s4_hue_d = (s3_q_q == 6'd0) ? 9'd0 : (9'd360 - 9'(s3_q_q));
      end else begin
        s4_hue_d = s4_base - 9'(s3_q_q);
      end
    end
    s4_px_d = {s4_hue_d, s3_sat_q, s3_mx_q};
  end

  // ---------------------------------------------------------------------
  // Arithmetic stage registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mx_q    <= 8'd0;
      s1_d_q     <= 8'd0;
      s1_absn_q  <= 8'd0;
      s1_neg_q   <= 1'b0;
      s1_sel_q   <= CH_R;
      s2_hprod_q <= 14'd0;
      s2_sprod_q <= 15'd0;
      s2_d_q     <= 8'd0;
      s2_mx_q    <= 8'd0;
      s2_neg_q   <= 1'b0;
      s2_sel_q   <= CH_R;
      s3_q_q     <= 6'd0;
      s3_sat_q   <= 7'd0;
      s3_dz_q    <= 1'b1;
      s3_neg_q   <= 1'b0;
      s3_mx_q    <= 8'd0;
      s3_sel_q   <= CH_R;
      s4_px_q    <= 24'd0;
    end else begin
      s1_mx_q    <= s1_mx_d;
      s1_d_q     <= s1_d_d;
      s1_absn_q  <= s1_absn_d;
      s1_neg_q   <= s1_neg_d;
      s1_sel_q   <= s1_sel_d;
      s2_hprod_q <= s2_hprod_d;
      s2_sprod_q <= s2_sprod_d;
      s2_d_q     <= s1_d_q;
      s2_mx_q    <= s1_mx_q;
      s2_neg_q   <= s1_neg_q;
      s2_sel_q   <= s1_sel_q;
      s3_q_q     <= s3_q_d;
      s3_sat_q   <= s3_sat_d;
      s3_dz_q    <= (s2_d_q == 8'd0);
      s3_neg_q   <= s2_neg_q;
      s3_mx_q    <= s2_mx_q;
      s3_sel_q   <= s2_sel_q;
      s4_px_q    <= s4_px_d;
    end
  end

  // ---------------------------------------------------------------------
  // Extra pixel delay stages beyond the arithmetic pipeline
  // ---------------------------------------------------------------------
  generate
    if (LATENCY > 4) begin : g_dly
      logic [23:0] dly_q [LATENCY-4];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY - 4; i++) dly_q[i] <= 24'd0;
        end else begin
          dly_q[0] <= s4_px_q;
          for (int i = 1; i < LATENCY - 4; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign pixel_out = dly_q[LATENCY-5];
    end else begin : g_nodly
      assign pixel_out = s4_px_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Valid and sideband shift registers, depth LATENCY
  // ---------------------------------------------------------------------
  logic        vld_q [LATENCY];
  logic [23:0] pas_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        pas_q[i] <= 24'd0;
      end
    end else begin
      vld_q[0] <= in_valid;
      pas_q[0] <= pass_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        pas_q[i] <= pas_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign pass_thru = pas_q[LATENCY-1];

endmodule

// File: tb/tb_rgb2hsv.sv
// tb/tb_rgb2hsv.sv - scoreboard bench for rgb2hsv at LATENCY 4 and 6

module tb_rgb2hsv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] pixel_in;
  logic [23:0] pass_in;

  logic        ov4, ov6;
  logic [23:0] px4, px6, pt4, pt6;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [23:0] px;
    logic [23:0] ps;
    int          due;
  } exp_t;

  exp_t q4[$];
  exp_t q6[$];
  exp_t e4, e6;

  rgb2hsv #(.LATENCY(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pixel_in  (pixel_in),
    .pass_in   (pass_in),
    .out_valid (ov4),
    .pixel_out (px4),
    .pass_thru (pt4)
  );

  rgb2hsv #(.LATENCY(6)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pixel_in  (pixel_in),
    .pass_in   (pass_in),
    .out_valid (ov6),
    .pixel_out (px6),
    .pass_thru (pt6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_hsv(input logic [23:0] p);
    int r, g, b, mx, mn, d, h, s;
    r  = int'(p[23:16]);
    g  = int'(p[15:8]);
    b  = int'(p[7:0]);
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d  = mx - mn;
    if (d == 0)       h = 0;
    else if (r == mx) h = (60 * (g - b)) / d;
    else if (g == mx) h = 120 + (60 * (b - r)) / d;
    else              h = 240 + (60 * (r - g)) / d;
    if (h < 0) h = h + 360;
    s = (mx == 0) ? 0 : (100 * d) / mx;
    return {h[8:0], s[6:0], mx[7:0]};
  endfunction

  task automatic drive(input logic v, input logic [23:0] rgb, input logic [23:0] ps,
                       input logic [23:0] ex);
    exp_t t;
    @(posedge clk);
    #1;
    in_valid = v;
    pixel_in = rgb;
    pass_in  = ps;
    if (v) begin
      t.px = ex; t.ps = ps;
      t.due = cyc + 4; q4.push_back(t);
      t.due = cyc + 6; q6.push_back(t);
    end
  endtask

  task automatic chk_zero(input string phase);
    chk({phase, "_ov4"}, 32'(ov4), 32'd0);
    chk({phase, "_px4"}, 32'(px4), 32'd0);
    chk({phase, "_pt4"}, 32'(pt4), 32'd0);
    chk({phase, "_ov6"}, 32'(ov6), 32'd0);
    chk({phase, "_px6"}, 32'(px6), 32'd0);
    chk({phase, "_pt6"}, 32'(pt6), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov4 === 1'b1) begin
      if (q4.size() == 0) begin
        chk("l4_spurious", 32'd1, 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk("l4_px", 32'(px4), 32'(e4.px));
        chk("l4_pass", 32'(pt4), 32'(e4.ps));
        chk("l4_lat", 32'(cyc), 32'(e4.due));
        chk("l4_hue_rng", 32'(px4[23:15] > 9'd359), 32'd0);
        chk("l4_sat_rng", 32'(px4[14:8] > 7'd100), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov6 === 1'b1) begin
      if (q6.size() == 0) begin
        chk("l6_spurious", 32'd1, 32'd0);
      end else begin
        e6 = q6.pop_front();
        chk("l6_px", 32'(px6), 32'(e6.px));
        chk("l6_pass", 32'(pt6), 32'(e6.ps));
        chk("l6_lat", 32'(cyc), 32'(e6.due));
        chk("l6_hue_rng", 32'(px6[23:15] > 9'd359), 32'd0);
        chk("l6_sat_rng", 32'(px6[14:8] > 7'd100), 32'd0);
      end
    end
  end

  logic [23:0] dir_rgb [6];
  logic [23:0] dir_exp [6];

  initial begin
    logic [23:0] rgb;
    logic        v;

    dir_rgb = '{24'h00FF00, 24'h000000, 24'h808080, 24'hFF0080, 24'hFFFF00, 24'hC86464};
    dir_exp = '{24'h3C64FF, 24'h000000, 24'h000080, 24'hA564FF, 24'h1E64FF, 24'h0032C8};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    pixel_in = 24'd0;
    pass_in  = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;

    // Directed vectors with spec-given expected words, with idle gaps
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, dir_rgb[i], 24'($urandom), dir_exp[i]);
      if (i % 2 == 1) drive(1'b0, 24'hABCDEF, 24'h0, 24'h0);
    end

    // Random stream against the reference model
    for (int i = 0; i < 1000; i++) begin
      rgb = 24'($urandom);
      v   = 1'($urandom_range(0, 1));
      drive(v, rgb, 24'($urandom), ref_hsv(rgb));
    end

    repeat (10) drive(1'b0, 24'h0, 24'h0, 24'h0);
    chk("drain1_q4", 32'(q4.size()), 32'd0);
    chk("drain1_q6", 32'(q6.size()), 32'd0);

    // Mid-stream reset with three pixels in flight
    drive(1'b1, 24'h00FF00, 24'h111111, 24'h3C64FF);
    drive(1'b1, 24'hFF0080, 24'h222222, 24'hA564FF);
    drive(1'b1, 24'hC86464, 24'h333333, 24'h0032C8);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_zero("midrst");
    q4.delete();
    q6.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    repeat (8) drive(1'b0, 24'h0, 24'h0, 24'h0);
    drive(1'b1, 24'hFFFF00, 24'h444444, 24'h1E64FF);
    repeat (10) drive(1'b0, 24'h0, 24'h0, 24'h0);
    chk("drain2_q4", 32'(q4.size()), 32'd0);
    chk("drain2_q6", 32'(q6.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
